// File: rtl/router_fsm.sv
// rtl/router_fsm.sv - packet-control FSM feeding the three router FIFOs
//
// Decodes the destination address from the header byte and sequences the
// header, payload and parity writes toward the addressed FIFO. It stalls the
// source on FIFO full or a busy destination, and abandons the packet on a
// soft reset of the destination port.
//
// Ports:
//   clock          system clock, rising edge
//   resetn         asynchronous active-low reset
//   pkt_valid      source presenting header/payload bytes
//   data_in        header address bits (sampled in DECODE_ADDRESS only)
//   fifo_full      full flag of the addressed FIFO (pre-muxed)
//   fifo_empty_0-2 empty flags of FIFO 0..2
//   soft_reset_0-2 timeout soft resets of port 0..2
//   parity_done    register stage has captured the parity byte
//   low_pkt_valid  register stage saw pkt_valid fall while holding a byte
//   busy           source must hold the current byte
//   detect_add     in DECODE_ADDRESS
//   lfd_state      in LOAD_FIRST_DATA (header marking)
//   ld_state       in LOAD_DATA
//   laf_state      in LOAD_AFTER_FULL
//   full_state     in FIFO_FULL_STATE
//   write_enb_reg  register stage may write toward the FIFO
//   rst_int_reg    in CHECK_PARITY_ERROR, clears internal parity/flag regs

module router_fsm #(
    parameter int ADDR_W = 2
) (
    input  logic              clock,
    input  logic              resetn,
    input  logic              pkt_valid,
    input  logic [ADDR_W-1:0] data_in,
    input  logic              fifo_full,
    input  logic              fifo_empty_0,
    input  logic              fifo_empty_1,
    input  logic              fifo_empty_2,
    input  logic              soft_reset_0,
    input  logic              soft_reset_1,
    input  logic              soft_reset_2,
    input  logic              parity_done,
    input  logic              low_pkt_valid,
    output logic              busy,
    output logic              detect_add,
    output logic              lfd_state,
    output logic              ld_state,
    output logic              laf_state,
    output logic              full_state,
    output logic              write_enb_reg,
    output logic              rst_int_reg
);

    typedef enum logic [2:0] {
        DECODE_ADDRESS     = 3'd0,
        LOAD_FIRST_DATA    = 3'd1,
        LOAD_DATA          = 3'd2,
        FIFO_FULL_STATE    = 3'd3,
        LOAD_AFTER_FULL    = 3'd4,
        WAIT_TILL_EMPTY    = 3'd5,
        LOAD_PARITY        = 3'd6,
        CHECK_PARITY_ERROR = 3'd7
    } state_t;

    localparam logic [ADDR_W-1:0] ADDR_INVALID = ADDR_W'(3);

    state_t            r_state;
    state_t            w_next_state;
    logic [ADDR_W-1:0] r_addr_q;

    logic w_empty_in;      // empty flag of the port named by data_in
    logic w_empty_q;       // empty flag of the latched destination
    logic w_soft_reset_q;  // soft reset of the latched destination
    logic w_hdr_valid;     // a routable header is on data_in

    // Each mux reads only the selected port so that X on the others cannot
    // leak into the next state.
    always_comb begin
        w_empty_in = 1'b0;
        case (data_in)
            ADDR_W'(0): w_empty_in = fifo_empty_0;
            ADDR_W'(1): w_empty_in = fifo_empty_1;
            ADDR_W'(2): w_empty_in = fifo_empty_2;
            default:    w_empty_in = 1'b0;
        endcase
    end

    always_comb begin
        w_empty_q      = 1'b0;
        w_soft_reset_q = 1'b0;
        case (r_addr_q)
            ADDR_W'(0): begin
                w_empty_q      = fifo_empty_0;
                w_soft_reset_q = soft_reset_0;
            end
            ADDR_W'(1): begin
                w_empty_q      = fifo_empty_1;
                w_soft_reset_q = soft_reset_1;
            end
            ADDR_W'(2): begin
                w_empty_q      = fifo_empty_2;
                w_soft_reset_q = soft_reset_2;
            end
            default: begin
                w_empty_q      = 1'b0;
                w_soft_reset_q = 1'b0;
            end
        endcase
    end

    // pkt_valid is tested first so a low pkt_valid masks an unknown data_in.
    assign w_hdr_valid = pkt_valid && (data_in != ADDR_INVALID);

    // State and destination registers
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            r_state  <= DECODE_ADDRESS;
            r_addr_q <= '0;
        end else begin
            r_state <= w_next_state;
            if (r_state == DECODE_ADDRESS && pkt_valid) begin
                r_addr_q <= data_in;
            end
        end
    end

    // Next-state logic
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            DECODE_ADDRESS: begin
                if (w_hdr_valid) begin
                    w_next_state = w_empty_in ? LOAD_FIRST_DATA : WAIT_TILL_EMPTY;
                end
            end
            WAIT_TILL_EMPTY: begin
                if (w_empty_q) begin
                    w_next_state = LOAD_FIRST_DATA;
                end
            end
            LOAD_FIRST_DATA: begin
                w_next_state = LOAD_DATA;
            end
            LOAD_DATA: begin
                if (fifo_full) begin
                    w_next_state = FIFO_FULL_STATE;
                end else if (!pkt_valid) begin
                    w_next_state = LOAD_PARITY;
                end
            end
            FIFO_FULL_STATE: begin
                if (!fifo_full) begin
                    w_next_state = LOAD_AFTER_FULL;
                end
            end
            LOAD_AFTER_FULL: begin
                if (parity_done) begin
                    w_next_state = DECODE_ADDRESS;
                end else if (low_pkt_valid) begin
                    w_next_state = LOAD_PARITY;
                end else begin
                    w_next_state = LOAD_DATA;
                end
            end
            LOAD_PARITY: begin
                w_next_state = CHECK_PARITY_ERROR;
            end
            CHECK_PARITY_ERROR: begin
                w_next_state = fifo_full ? FIFO_FULL_STATE : DECODE_ADDRESS;
            end
            default: begin
                w_next_state = DECODE_ADDRESS;
            end
        endcase

        // Destination timed out: abandon the packet from any state.
        if (w_soft_reset_q) begin
            w_next_state = DECODE_ADDRESS;
        end
    end

    // Moore outputs
    always_comb begin
        detect_add    = (r_state == DECODE_ADDRESS);
        lfd_state     = (r_state == LOAD_FIRST_DATA);
        ld_state      = (r_state == LOAD_DATA);
        laf_state     = (r_state == LOAD_AFTER_FULL);
        full_state    = (r_state == FIFO_FULL_STATE);
        rst_int_reg   = (r_state == CHECK_PARITY_ERROR);
        busy          = !((r_state == DECODE_ADDRESS) || (r_state == LOAD_DATA));
        write_enb_reg = (r_state == LOAD_DATA) || (r_state == LOAD_PARITY) ||
                        (r_state == LOAD_AFTER_FULL);
    end

endmodule

// File: tb/tb_router_fsm.sv
// tb/tb_router_fsm.sv - directed self-checking bench for router_fsm

module tb_router_fsm;

    logic       clock;
    logic       resetn;
    logic       pkt_valid;
    logic [1:0] data_in;
    logic       fifo_full;
    logic       fifo_empty_0, fifo_empty_1, fifo_empty_2;
    logic       soft_reset_0, soft_reset_1, soft_reset_2;
    logic       parity_done;
    logic       low_pkt_valid;
    logic       busy, detect_add, lfd_state, ld_state, laf_state;
    logic       full_state, write_enb_reg, rst_int_reg;

    int checks = 0;
    int errors = 0;

    // Expected output vectors {busy,detect_add,lfd,ld,laf,full,write_enb,rst_int}
    localparam logic [7:0] E_DEC  = 8'b0100_0000;
    localparam logic [7:0] E_LFD  = 8'b1010_0000;
    localparam logic [7:0] E_LD   = 8'b0001_0010;
    localparam logic [7:0] E_LAF  = 8'b1000_1010;
    localparam logic [7:0] E_FULL = 8'b1000_0100;
    localparam logic [7:0] E_WAIT = 8'b1000_0000;
    localparam logic [7:0] E_LP   = 8'b1000_0010;
    localparam logic [7:0] E_CPE  = 8'b1000_0001;

    router_fsm dut (
        .clock         (clock),
        .resetn        (resetn),
        .pkt_valid     (pkt_valid),
        .data_in       (data_in),
        .fifo_full     (fifo_full),
        .fifo_empty_0  (fifo_empty_0),
        .fifo_empty_1  (fifo_empty_1),
        .fifo_empty_2  (fifo_empty_2),
        .soft_reset_0  (soft_reset_0),
        .soft_reset_1  (soft_reset_1),
        .soft_reset_2  (soft_reset_2),
        .parity_done   (parity_done),
        .low_pkt_valid (low_pkt_valid),
        .busy          (busy),
        .detect_add    (detect_add),
        .lfd_state     (lfd_state),
        .ld_state      (ld_state),
        .laf_state     (laf_state),
        .full_state    (full_state),
        .write_enb_reg (write_enb_reg),
        .rst_int_reg   (rst_int_reg)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    // Inputs change and outputs are sampled on the falling edge.
    task automatic step();
        @(negedge clock);
    endtask

    task automatic chk(input string tag, input logic [7:0] exp);
        logic [7:0] obs;
        obs = {busy, detect_add, lfd_state, ld_state, laf_state,
               full_state, write_enb_reg, rst_int_reg};
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    initial begin
        resetn        = 1'b0;
        pkt_valid     = 1'b0;
        data_in       = 2'd0;
        fifo_full     = 1'b0;
        fifo_empty_0  = 1'b1;
        fifo_empty_1  = 1'b1;
        fifo_empty_2  = 1'b1;
        soft_reset_0  = 1'b0;
        soft_reset_1  = 1'b0;
        soft_reset_2  = 1'b0;
        parity_done   = 1'b0;
        low_pkt_valid = 1'b0;

        step();
        step();
        chk("reset", E_DEC);
        resetn = 1'b1;
        step();
        chk("idle", E_DEC);

        // Normal packet to port 1, four payload cycles
        pkt_valid = 1'b1;
        data_in   = 2'd1;
        step();
        chk("norm_lfd", E_LFD);
        data_in = 2'bxx;
        for (int i = 0; i < 4; i++) begin
            step();
            chk($sformatf("norm_ld%0d", i), E_LD);
        end
        pkt_valid = 1'b0;
        step();
        chk("norm_lp", E_LP);
        step();
        chk("norm_cpe", E_CPE);
        step();
        chk("norm_dec", E_DEC);

        // Busy destination: port 2 not empty for five cycles
        fifo_empty_2 = 1'b0;
        pkt_valid    = 1'b1;
        data_in      = 2'd2;
        step();
        chk("wait0", E_WAIT);
        data_in = 2'bxx;
        for (int i = 1; i < 5; i++) begin
            step();
            chk($sformatf("wait%0d", i), E_WAIT);
        end
        fifo_empty_2 = 1'b1;
        step();
        chk("wait_lfd", E_LFD);
        step();
        chk("wait_ld", E_LD);

        // Full mid-payload for three cycles, then low_pkt_valid -> parity
        fifo_full = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            chk($sformatf("full%0d", i), E_FULL);
        end
        fifo_full = 1'b0;
        step();
        chk("laf_a", E_LAF);
        low_pkt_valid = 1'b1;
        pkt_valid     = 1'b0;
        step();
        chk("laf_low_lp", E_LP);
        low_pkt_valid = 1'b0;
        step();
        chk("laf_cpe", E_CPE);
        fifo_full = 1'b1;
        step();
        chk("cpe_full", E_FULL);
        fifo_full = 1'b0;
        step();
        chk("laf_b", E_LAF);
        parity_done = 1'b1;
        step();
        chk("laf_pd_dec", E_DEC);
        parity_done = 1'b0;

        // LOAD_AFTER_FULL with neither flag -> back to LOAD_DATA
        pkt_valid = 1'b1;
        data_in   = 2'd2;
        step();
        chk("p3_lfd", E_LFD);
        step();
        chk("p3_ld", E_LD);
        fifo_full = 1'b1;
        step();
        chk("p3_full", E_FULL);
        fifo_full = 1'b0;
        step();
        chk("p3_laf", E_LAF);
        step();
        chk("laf_ld", E_LD);
        pkt_valid = 1'b0;
        step();
        chk("p3_lp", E_LP);
        step();
        chk("p3_cpe", E_CPE);
        step();
        chk("p3_dec", E_DEC);

        // Soft reset: other port ignored, own port aborts
        pkt_valid = 1'b1;
        data_in   = 2'd0;
        step();
        chk("sr_lfd", E_LFD);
        step();
        chk("sr_ld", E_LD);
        soft_reset_1 = 1'b1;
        step();
        chk("sr_other", E_LD);
        soft_reset_1 = 1'b0;
        soft_reset_0 = 1'b1;
        step();
        chk("sr_own", E_DEC);
        soft_reset_0 = 1'b0;
        pkt_valid    = 1'b0;
        step();
        chk("sr_idle", E_DEC);

        // Invalid address 3 is dropped
        pkt_valid = 1'b1;
        data_in   = 2'd3;
        for (int i = 0; i < 4; i++) begin
            step();
            chk($sformatf("inval%0d", i), E_DEC);
        end
        pkt_valid = 1'b0;

        // Asynchronous reset mid-packet, between clock edges
        pkt_valid = 1'b1;
        data_in   = 2'd1;
        step();
        chk("ar_lfd", E_LFD);
        step();
        chk("ar_ld", E_LD);
        #2 resetn = 1'b0;
        #1 chk("async_reset", E_DEC);
        step();
        chk("reset_hold", E_DEC);
        resetn    = 1'b1;
        pkt_valid = 1'b0;
        step();
        chk("post_reset", E_DEC);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
